// File: rtl/matrix_mul_engine.sv
// Square matrix multiplier C = A x B over a shared single-port RAM, with a
// host load/readback port, sticky config-error/overflow flags and optional saturation.
module matrix_mul_engine #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 9,
   parameter int DIM_MAX = 8,
   parameter int SAT     = 0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [$clog2(DIM_MAX+1)-1:0]   n_dim,
   input  logic [ADDR_W-1:0]              base_a,
   input  logic [ADDR_W-1:0]              base_b,
   input  logic [ADDR_W-1:0]              base_c,
   input  logic                           host_we,
   input  logic [ADDR_W-1:0]              host_addr,
   input  logic [DATA_W-1:0]              host_wdata,
   output logic [DATA_W-1:0]              host_rdata,
   output logic                           busy,
   output logic                           done,
   output logic                           err,
   output logic                           ovf
);

   localparam int N_W   = $clog2(DIM_MAX + 1);
   localparam int AW    = ADDR_W + 7;
   localparam int ACC_W = 2 * DATA_W + $clog2(DIM_MAX);
   localparam logic [AW-1:0] LIM = AW'(1) << ADDR_W;

   typedef enum logic [2:0] {IDLE, CHECK, RD_A, RD_B, MAC, WR, DONE, ERR} state_t;

   state_t state, state_nx;

   logic [N_W-1:0]            n_q, i_q, j_q, k_q;
   logic [ADDR_W-1:0]         base_a_q, base_b_q, base_c_q;
   logic signed [ACC_W-1:0]   acc;
   logic signed [DATA_W-1:0]  a_q;
   logic [DATA_W-1:0]         ram_q;
   logic                      host_rd_ok;
   logic [DATA_W-1:0]         mem [0:(1<<ADDR_W)-1];

   logic [AW-1:0]             nn;
   logic                      cfg_bad;
   logic                      k_last, j_last, i_last;
   logic [ACC_W-DATA_W:0]     acc_hi;
   logic                      ovf_now;
   logic [DATA_W-1:0]         result;
   logic signed [2*DATA_W-1:0] prod;
   logic [ADDR_W-1:0]         addr_a, addr_b, addr_c;
   logic [ADDR_W-1:0]         ram_addr;
   logic                      ram_we;
   logic [DATA_W-1:0]         ram_wdata;

   // Region bounds are checked in a widened space so base + n*n cannot wrap.
   always_comb begin
      nn      = AW'(n_q) * AW'(n_q);
      cfg_bad = (n_q == '0) || (n_q > N_W'(DIM_MAX)) ||
                (AW'(base_a_q) + nn > LIM) ||
                (AW'(base_b_q) + nn > LIM) ||
                (AW'(base_c_q) + nn > LIM);
   end

   assign k_last = (k_q == n_q - N_W'(1));
   assign j_last = (j_q == n_q - N_W'(1));
   assign i_last = (i_q == n_q - N_W'(1));

   assign addr_a = ADDR_W'(AW'(base_a_q) + AW'(i_q) * AW'(n_q) + AW'(k_q));
   assign addr_b = ADDR_W'(AW'(base_b_q) + AW'(k_q) * AW'(n_q) + AW'(j_q));
   assign addr_c = ADDR_W'(AW'(base_c_q) + AW'(i_q) * AW'(n_q) + AW'(j_q));

   assign prod = a_q * $signed(ram_q);

   // The accumulator fits DATA_W only when every bit above the sign bit matches it.
   always_comb begin
      acc_hi  = acc[ACC_W-1:DATA_W-1];
      ovf_now = !((&acc_hi) || (~|acc_hi));
      result  = acc[DATA_W-1:0];
      if ((SAT != 0) && ovf_now) begin
         result = acc[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   // The host owns the RAM port only while idle; otherwise the sequencer drives it.
   always_comb begin
      state_nx  = state;
      ram_addr  = host_addr;
      ram_we    = 1'b0;
      ram_wdata = host_wdata;
      case (state)
         IDLE: begin
            ram_we = host_we;
            if (start) state_nx = CHECK;
         end
         CHECK: state_nx = cfg_bad ? ERR : RD_A;
         RD_A: begin
            ram_addr = addr_a;
            state_nx = RD_B;
         end
         RD_B: begin
            ram_addr = addr_b;
            state_nx = MAC;
         end
         MAC:  state_nx = k_last ? WR : RD_A;
         WR: begin
            ram_addr  = addr_c;
            ram_we    = 1'b1;
            ram_wdata = result;
            state_nx  = (i_last && j_last) ? DONE : RD_A;
         end
         ERR:  state_nx = DONE;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_q <= mem[ram_addr];
   end

   assign host_rdata = host_rd_ok ? ram_q : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         n_q        <= '0;
         i_q        <= '0;
         j_q        <= '0;
         k_q        <= '0;
         base_a_q   <= '0;
         base_b_q   <= '0;
         base_c_q   <= '0;
         acc        <= '0;
         a_q        <= '0;
         err        <= 1'b0;
         ovf        <= 1'b0;
         host_rd_ok <= 1'b0;
      end else begin
         host_rd_ok <= (state == IDLE);
         case (state)
            IDLE: begin
               if (start) begin
                  n_q      <= n_dim;
                  base_a_q <= base_a;
                  base_b_q <= base_b;
                  base_c_q <= base_c;
                  err      <= 1'b0;
                  ovf      <= 1'b0;
               end
            end
            CHECK: begin
               i_q <= '0;
               j_q <= '0;
               k_q <= '0;
               acc <= '0;
            end
            RD_B: a_q <= $signed(ram_q);
            MAC: begin
               acc <= acc + ACC_W'(prod);
               if (!k_last) k_q <= k_q + N_W'(1);
            end
            WR: begin
               if (ovf_now) ovf <= 1'b1;
               k_q <= '0;
               acc <= '0;
               if (j_last) begin
                  j_q <= '0;
                  i_q <= i_q + N_W'(1);
               end else begin
                  j_q <= j_q + N_W'(1);
               end
            end
            ERR: err <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_mul_engine.sv
// Drives a wrapping and a saturating engine in lockstep and compares them
// against an arithmetic matrix-product model of the RAM contents.
module tb_matrix_mul_engine;

   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 9;
   localparam int DIM_MAX = 8;
   localparam int N_W     = $clog2(DIM_MAX + 1);
   localparam int DEPTH   = 1 << ADDR_W;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 start = 1'b0;
   logic [N_W-1:0]       n_dim = '0;
   logic [ADDR_W-1:0]    base_a = '0, base_b = '0, base_c = '0, host_addr = '0;
   logic                 host_we = 1'b0;
   logic [DATA_W-1:0]    host_wdata = '0;
   logic [DATA_W-1:0]    rdata_w, rdata_s;
   logic [1:0]           busy, done, err, ovf;

   int tests = 0;
   int fails = 0;
   logic [DATA_W-1:0] model [2][DEPTH];
   logic [1:0]        exp_ovf;

   matrix_mul_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_MAX(DIM_MAX), .SAT(0)) dut_w (
      .clk(clk), .rst(rst), .start(start), .n_dim(n_dim),
      .base_a(base_a), .base_b(base_b), .base_c(base_c),
      .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_rdata(rdata_w), .busy(busy[0]), .done(done[0]), .err(err[0]), .ovf(ovf[0])
   );

   matrix_mul_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_MAX(DIM_MAX), .SAT(1)) dut_s (
      .clk(clk), .rst(rst), .start(start), .n_dim(n_dim),
      .base_a(base_a), .base_b(base_b), .base_c(base_c),
      .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_rdata(rdata_s), .busy(busy[1]), .done(done[1]), .err(err[1]), .ovf(ovf[1])
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic host_write(input int addr, input logic [DATA_W-1:0] data);
      host_we    = 1'b1;
      host_addr  = ADDR_W'(addr);
      host_wdata = data;
      @(posedge clk); #1;
      host_we = 1'b0;
      model[0][addr] = data;
      model[1][addr] = data;
   endtask

   task automatic host_read_check(input int addr, input string tag);
      host_addr = ADDR_W'(addr);
      @(posedge clk); #1;
      check_output($sformatf("%s[%0d]_wrap", tag, addr), 64'(rdata_w), 64'(model[0][addr]));
      check_output($sformatf("%s[%0d]_sat", tag, addr), 64'(rdata_s), 64'(model[1][addr]));
   endtask

   // Reference: exact dot products in 96 bits, then wrap or clamp per instance.
   task automatic model_run(input int n, input int ba, input int bb, input int bc);
      logic signed [95:0] sum;
      exp_ovf = '0;
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
               sum = '0;
               for (int k = 0; k < n; k++)
                  sum = sum + $signed(model[s][ba + i*n + k]) * $signed(model[s][bb + k*n + j]);
               if (sum > 96'sd2147483647) begin
                  exp_ovf[s] = 1'b1;
                  model[s][bc + i*n + j] = (s == 1) ? 32'h7FFF_FFFF : sum[31:0];
               end else if (sum < -96'sd2147483648) begin
                  exp_ovf[s] = 1'b1;
                  model[s][bc + i*n + j] = (s == 1) ? 32'h8000_0000 : sum[31:0];
               end else begin
                  model[s][bc + i*n + j] = sum[31:0];
               end
            end
         end
      end
   endtask

   task automatic apply_stimulus(input int n, input int ba, input int bb, input int bc,
                                 input bit disturb, output int lat);
      start  = 1'b1;
      n_dim  = N_W'(n);
      base_a = ADDR_W'(ba);
      base_b = ADDR_W'(bb);
      base_c = ADDR_W'(bc);
      @(posedge clk); #1;
      start  = 1'b0;
      n_dim  = N_W'($urandom);
      base_a = ADDR_W'($urandom);
      base_b = ADDR_W'($urandom);
      base_c = ADDR_W'($urandom);
      lat = 0;
      while (lat < 2000) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 1) check_output("busy_after_start", 64'(busy), 64'(2'b11));
         if (done[0]) break;
         if (disturb) begin
            if (lat == 20) begin
               start = 1'b1; host_we = 1'b1; host_addr = 9'd450; host_wdata = 32'hDEAD_BEEF;
            end else if (lat == 21) begin
               start = 1'b0; host_we = 1'b0; host_addr = 9'd451;
            end else if (lat == 22) begin
               check_output("rdata_while_busy", 64'(rdata_w), 64'd0);
            end
         end
      end
      if (lat >= 2000) check_output("done_timeout", 64'(done), 64'(2'b11));
      else             check_output("done_both", 64'(done), 64'(2'b11));
   endtask

   task automatic run_op(input int n, input int ba, input int bb, input int bc,
                         input bit disturb, input string tag);
      int lat;
      int exp_lat;
      bit bad;
      bad = (n == 0) || (n > DIM_MAX) || (ba + n*n - 1 > DEPTH - 1) ||
            (bb + n*n - 1 > DEPTH - 1) || (bc + n*n - 1 > DEPTH - 1);
      exp_lat = bad ? 2 : 1 + n*n*(3*n + 1);
      apply_stimulus(n, ba, bb, bc, disturb, lat);
      check_output({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check_output({tag, "_err"}, 64'(err), bad ? 64'(2'b11) : 64'd0);
      if (!bad) model_run(n, ba, bb, bc);
      else      exp_ovf = '0;
      check_output({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
      @(posedge clk); #1;
      check_output({tag, "_done_pulse"}, 64'(done), 64'd0);
      check_output({tag, "_busy_drop"}, 64'(busy), 64'd0);
      if (!bad) begin
         for (int w = 0; w < n*n; w++) host_read_check(bc + w, tag);
      end else begin
         for (int w = 0; w < n*n && w < 4 && bc + w < DEPTH; w++) host_read_check(bc + w, tag);
      end
   endtask

   initial begin
      int exp_c[4];
      int extra;
      int rn;
      exp_c = '{19, 22, 43, 50};

      // Reset values while held in reset
      #2;
      check_output("rst_busy", 64'(busy), 64'd0);
      check_output("rst_done", 64'(done), 64'd0);
      check_output("rst_err", 64'(err), 64'd0);
      check_output("rst_ovf", 64'(ovf), 64'd0);
      check_output("rst_rdata", 64'({rdata_w, rdata_s}), 64'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;

      // n=2 reference example
      for (int w = 0; w < 4; w++) host_write(w, DATA_W'(w + 1));
      for (int w = 0; w < 4; w++) host_write(4 + w, DATA_W'(w + 5));
      host_read_check(2, "load");
      run_op(2, 0, 4, 8, 1'b0, "n2");
      for (int w = 0; w < 4; w++) begin
         host_addr = ADDR_W'(8 + w);
         @(posedge clk); #1;
         check_output($sformatf("n2_const[%0d]", w), 64'(rdata_w), 64'(exp_c[w]));
      end

      // Overflow: positive, negative, then exact lower bound (clean)
      host_write(20, 32'h4000_0000); host_write(21, 32'd4);
      run_op(1, 20, 21, 22, 1'b0, "ovf_pos");
      host_write(21, 32'hFFFF_FFFC);
      run_op(1, 20, 21, 22, 1'b0, "ovf_neg");
      host_write(20, 32'hC000_0000); host_write(21, 32'd2);
      run_op(1, 20, 21, 22, 1'b0, "ovf_edge_clean");

      // Config errors leave C untouched; then a boundary-legal region
      host_write(510, 32'hAAAA_5555); host_write(511, 32'h1234_0000);
      run_op(0, 0, 4, 8, 1'b0, "err_n0");
      run_op(DIM_MAX + 1, 0, 4, 8, 1'b0, "err_nbig");
      run_op(2, 0, 4, 510, 1'b0, "err_range");
      run_op(2, 0, 4, 508, 1'b0, "edge_range");

      // n=3 with start and host write pulsed mid-run
      host_write(450, 32'h0BAD_F00D); host_write(451, 32'h1234_5678);
      for (int w = 0; w < 9; w++) host_write(30 + w, DATA_W'($urandom_range(0, 2000)) - 32'd1000);
      for (int w = 0; w < 9; w++) host_write(40 + w, DATA_W'($urandom_range(0, 2000)) - 32'd1000);
      run_op(3, 30, 40, 50, 1'b1, "n3_dist");
      extra = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (done != 2'b00) extra++;
      end
      check_output("n3_single_done", 64'(extra), 64'd0);
      host_read_check(450, "n3_no_host_write");

      // Asynchronous reset mid-run, then a clean rerun
      for (int w = 0; w < 4; w++) host_write(60 + w, 32'h4000_0000);
      for (int w = 0; w < 4; w++) host_write(64 + w, 32'd4);
      start = 1'b1; n_dim = N_W'(2); base_a = 9'd60; base_b = 9'd64; base_c = 9'd70;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      check_output("pre_rst_ovf", 64'(ovf), 64'(2'b11));
      check_output("pre_rst_busy", 64'(busy), 64'(2'b11));
      rst = 1'b0;
      #1;
      check_output("mid_rst_busy", 64'(busy), 64'd0);
      check_output("mid_rst_done", 64'(done), 64'd0);
      check_output("mid_rst_err", 64'(err), 64'd0);
      check_output("mid_rst_ovf", 64'(ovf), 64'd0);
      #3 rst = 1'b1;
      @(posedge clk); #1;
      run_op(2, 60, 64, 70, 1'b0, "after_rst");

      // n=DIM_MAX: A all -1, B identity
      for (int w = 0; w < 64; w++) host_write(w, 32'hFFFF_FFFF);
      for (int w = 0; w < 64; w++) host_write(64 + w, (w / 8 == w % 8) ? 32'd1 : 32'd0);
      run_op(DIM_MAX, 0, 64, 128, 1'b0, "n8_ident");

      // Random sizes and full-range random operands
      for (int r = 0; r < 3; r++) begin
         rn = $urandom_range(1, DIM_MAX);
         for (int w = 0; w < rn*rn; w++) host_write(200 + w, DATA_W'($urandom));
         for (int w = 0; w < rn*rn; w++) host_write(280 + w, DATA_W'($urandom));
         run_op(rn, 200, 280, 360, 1'b0, $sformatf("rand%0d_n%0d", r, rn));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/matrix_mul_engine.md
Name: matrix_mul_engine

Overview:
- Parametrised successor to the fixed matrix multiplier top level.
- Computes C = A x B for runtime-selectable square size n (1..DIM_MAX) on signed DATA_W integers.
- Matrices are stored row-major in an internal single-port synchronous RAM, with run-time base addresses.
- Adds a host load/readback port, sticky config-error and overflow reporting, and an optional saturation mode; sits under the system top level in place of the fixed control-unit/RAM pair.

Parameters:
- DATA_W, 32: element width, signed two's complement.
- ADDR_W, 9: RAM address width; depth = 2**ADDR_W words.
- DIM_MAX, 8: largest supported n.
- SAT, 0: 0 = wrap result to DATA_W bits; 1 = saturate to signed DATA_W range.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- n_dim  in  $clog2(DIM_MAX+1)  matrix size, sampled with start.
- base_a  in  ADDR_W  word address of A[0][0].
- base_b  in  ADDR_W  word address of B[0][0].
- base_c  in  ADDR_W  word address of C[0][0].
- host_we  in  1  host write strobe; honoured only when busy=0.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_rdata  out  DATA_W  host read data, 1-cycle latency.
- busy  out  1  high from accepted start until return to IDLE.
- done  out  1  one-cycle completion pulse (success or error).
- err  out  1  sticky config error.
- ovf  out  1  sticky overflow flag.

Behaviour:
- Reset (rst=0, async): state=IDLE; busy, done, err, ovf, host_rdata = 0; indices and accumulator cleared. RAM contents are not cleared. Reset mid-operation aborts immediately; partially written C words remain.
- Base addresses and n_dim are latched at start. Later changes have no effect until the next start.
- Layout: X[r][c] at base_x + r*n + c. Address arithmetic is ADDR_W+7 bits wide, with no wrap.
- FSM states: IDLE, CHECK, RD_A, RD_B, MAC, WR, DONE, ERR.
  - IDLE: start=1 -> CHECK. Clears err and ovf and latches config. busy=1 from the next cycle.
  - CHECK (1 cycle): go to ERR if n=0, n>DIM_MAX, or for any X in {a,b,c} base_x + n*n - 1 > 2**ADDR_W-1. Otherwise set i=j=k=0, acc=0, and go to RD_A.
  - RD_A: RAM addr = A[i][k].
  - RD_B: RAM addr = B[k][j]; A word captured.
  - MAC: acc += A*B, full-precision signed. Accumulator width is 2*DATA_W + $clog2(DIM_MAX). If k<n-1: k++ -> RD_A; else -> WR.
  - WR: write C[i][j] = result. Then k=0, acc=0, advance j (then i on j wrap) -> RD_A; after the last element -> DONE.
  - Result with SAT=0: acc[DATA_W-1:0]. With SAT=1: clamp to [-2**(DATA_W-1), 2**(DATA_W-1)-1].
  - ovf is set if acc is outside the signed DATA_W range at WR, in either mode.
  - DONE: done=1 for one cycle, then IDLE; busy=0 in IDLE.
  - ERR: err=1 and done=1 for one cycle, no RAM writes, then IDLE. err stays high until the next accepted start.
- Latency: with start sampled at edge T0, done is high during the cycle after edge T0+1+n*n*(3n+1). n=1 -> 5; n=2 -> 29. The error path gives done after edge T0+2.
- Simultaneous events: start while busy is ignored. host_we while busy is ignored with no RAM write. Host reads while busy return 0. start together with host_we in IDLE: the host write completes and the start is accepted.
- The operands may overlap C; the result is defined only for non-overlapping regions.

Test Plan:
- n=2, A=[1,2,3,4]@0, B=[5,6,7,8]@4, base_c=8, loaded via host port -> done 29 cycles after start; readback 8..11 = 19,22,43,50; err=0, ovf=0.
- n=1, A=0x40000000, B=4, SAT=0 -> C=0x00000000 and ovf=1. Same stimulus with SAT=1 -> C=0x7FFFFFFF and ovf=1. A following clean run clears ovf.
- n_dim=0, then n_dim=DIM_MAX+1, then n=2 with base_c=510 -> each gives err=1 and done 2 cycles after start; C region unchanged; busy drops after done.
- n=3 run with start re-pulsed and host_we=1 mid-run -> second start ignored, no host write occurs, single done at 1+9*10=91 cycles; results correct.
- rst asserted mid-run at cycle 10 -> busy, done, err, ovf = 0 asynchronously. A new start after release completes normally with correct C.
- n=DIM_MAX=8 with signed values (A=-1 everywhere, B=identity) -> C = -1 everywhere; done after 1+64*25=1601 cycles.
